bus_responder: RTL and testbench

Memory-side responder for the core's single-master bus (`address`, write data, `we`, read data). Decodes each bus access into a word-addressed RAM or a small MMIO page holding a console UART transmitter with byte FIFO, a free-running cycle counter and a halt flag. Sits between the core and the board pins/testbench. Provides the program/data store and the only observable program output.

---
 rtl/bus_responder_if.sv | 10 +
 rtl/bus_responder.sv | 176 +++++++++++++++++
 tb/tb_bus_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_if.sv
// Core-to-responder bus: byte address, write data, write enable, registered read data.
interface bus_responder_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output address, output wdata, output we, input rdata);
  modport slave  (input address, input wdata, input we, output rdata);
endinterface

// File: rtl/bus_responder.sv
// Memory-side bus responder: word RAM plus MMIO page holding a UART TX with
// byte FIFO, a free-running cycle counter and a sticky halt flag.
module bus_responder #(
  parameter int MEM_WORDS    = 4096,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  bus_responder_if.slave  bus,
  output logic            tx,
  output logic            halt
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- decode ----------------
  logic          ram_sel, mmio_sel;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          ram_wr, push_req, halt_set;
  logic          unused_ok;

  assign ram_sel   = (bus.address[31:AW+2] == '0);
  assign mmio_sel  = (bus.address[31:4] == 28'h8000000);
  assign reg_sel   = bus.address[3:2];
  assign ram_idx   = bus.address[AW+1:2];
  assign ram_wr    = bus.we & ram_sel;
  assign push_req  = bus.we & mmio_sel & (reg_sel == 2'd0);
  assign halt_set  = bus.we & mmio_sel & (reg_sel == 2'd3);
  assign unused_ok = &{1'b0, bus.address[1:0]};

  // ---------------- state ----------------
  logic [31:0]   mem [MEM_WORDS];
  logic [7:0]    fmem [FIFO_DEPTH];
  logic [FW-1:0] wptr_q, rptr_q;
  logic [FW:0]   cnt_q;
  logic [31:0]   cyc_q, rdata_q, rdata_d;
  logic          halt_q;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          pop, push, fifo_empty, fifo_full, tx_busy, baud_last;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (FW+1)'(FIFO_DEPTH));
  assign tx_busy    = (state_q != S_IDLE);
  assign baud_last  = (baud_q == BW'(CLKS_PER_BIT-1));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push       = push_req & (~fifo_full | pop);

  // RAM write port; no reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[ram_idx] <= bus.wdata;
  end

  // Read mux; RAM is read combinationally before the write lands (read-first).
  always_comb begin
    rdata_d = '0;
    if (ram_sel) begin
      rdata_d = mem[ram_idx];
    end else if (mmio_sel) begin
      case (reg_sel)
        2'd1:    rdata_d = {29'b0, tx_busy, fifo_empty, fifo_full};
        2'd2:    rdata_d = cyc_q;
        2'd3:    rdata_d = {31'b0, halt_q};
        default: rdata_d = '0;
      endcase
    end
  end

  // Registered read data, counter and sticky halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      cyc_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      cyc_q   <= cyc_q + 32'd1;
      if (halt_set) halt_q <= 1'b1;
    end
  end

  // FIFO storage; pointers/count carry the validity so no reset needed here.
  always_ff @(posedge clk) begin
    if (push) fmem[wptr_q] <= bus.wdata[7:0];
  end

  // FIFO pointers and occupancy; reset flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + FW'(1);
      if (pop)  rptr_q <= rptr_q + FW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (FW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (FW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // UART state registers; tx is registered so it trails the FSM state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // UART next-state: baud counter clears on every state or bit change.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fmem[rptr_q];
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = sh_q[bit_q];
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rdata = rdata_q;
  assign tx        = tx_q;
  assign halt      = halt_q;
endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: stimulus queues expected read data and
// UART bytes; independent monitors compare rdata and decoded tx frames.
module tb_bus_responder;
  localparam int MW = 1024;
  localparam int FD = 8;
  localparam int C  = 4;
  localparam logic [31:0] A_TX = 32'h8000_0000, A_ST = 32'h8000_0004,
                          A_CY = 32'h8000_0008, A_HL = 32'h8000_000C,
                          A_NONE = 32'hF000_0000;

  logic clk = 1'b0;
  logic reset;
  logic tx, halt;
  bus_responder_if bus();

  bus_responder #(.MEM_WORDS(MW), .FIFO_DEPTH(FD), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .halt(halt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];
  logic rd_req = 1'b0, rd_seen = 1'b0, rst_seen = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    rd_seen  <= rd_req;
    rst_seen <= reset;
  end

  // rdata monitor: compares one cycle after each issued read address.
  initial forever begin
    @(negedge clk);
    if (rd_seen) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %h expected nothing queued", bus.rdata);
      end else begin
        check(rd_name_q.pop_front(), bus.rdata, rd_exp_q.pop_front());
      end
    end
  end

  // UART decoder: samples mid-bit, aborts on reset.
  logic       dbusy = 1'b0;
  int         dcnt = 0;
  logic [7:0] dbyte = '0;
  initial forever begin
    @(negedge clk);
    if (rst_seen === 1'b1) begin
      dbusy = 1'b0;
    end else if (!dbusy) begin
      if (tx === 1'b0) begin dbusy = 1'b1; dcnt = 0; end
    end else begin
      dcnt++;
      if (dcnt == C/2) check("uart_start", {31'b0, tx}, 32'd0);
      else if (dcnt > C/2 && (dcnt - C/2) % C == 0) begin
        if ((dcnt - C/2) / C <= 8) dbyte[(dcnt - C/2) / C - 1] = tx;
        else begin
          check("uart_stop", {31'b0, tx}, 32'd1);
          if (tx_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL uart_unexpected: got byte %h expected none", dbyte);
          end else check("uart_byte", {24'b0, dbyte}, {24'b0, tx_exp_q.pop_front()});
          dbusy = 1'b0;
        end
      end
    end
  end

  // Stimulus tasks enter and leave on a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.address = a; bus.wdata = d; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus.we = 1'b0; bus.address = a;
    rd_exp_q.push_back(exp); rd_name_q.push_back(nm);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wrrd(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp,
                      input string nm);
    bus.address = a; bus.wdata = d; bus.we = 1'b1;
    rd_exp_q.push_back(exp); rd_name_q.push_back(nm);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.we = 1'b0; bus.address = A_NONE;
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] ca, cb;
  logic [9:0]  pat;

  initial begin
    bus.address = A_NONE; bus.wdata = '0; bus.we = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_halt", {31'b0, halt}, 32'd0);
    reset = 1'b0;
    rd(A_ST, 32'h2, "status_reset");

    // RAM
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10, 32'hDEADBEEF, "ram_rd");
    rd(32'h13, 32'hDEADBEEF, "ram_rd_unaligned");
    wrrd(32'h10, 32'h1, 32'hDEADBEEF, "ram_read_first");
    rd(32'h10, 32'h1, "ram_new");
    wr(32'hFFC, 32'hCAFEF00D);
    rd(32'hFFC, 32'hCAFEF00D, "ram_top");

    // Unmapped
    wr(32'h0, 32'h12345678);
    wr(32'h4000_0000, 32'hAAAA5555);
    wr(32'h8000_0010, 32'h55);
    rd(32'h4000_0000, 32'h0, "unmapped_rd");
    rd(32'h0, 32'h12345678, "unmapped_ram0");
    rd(A_ST, 32'h2, "unmapped_status");
    rd(A_HL, 32'h0, "unmapped_halt");
    rd(32'h8000_0010, 32'h0, "unmapped_mmio_rd");
    rd(A_TX, 32'h0, "txdata_rd");

    // Cycle counter
    bus.address = A_CY;
    @(negedge clk); ca = bus.rdata;
    repeat (5) @(negedge clk); cb = bus.rdata;
    check("cycle_diff", cb - ca, 32'd5);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1 release dut.cyc_q;
    @(negedge clk);
    check("cycle_pre_wrap", bus.rdata, 32'hFFFF_FFFF);
    check("cycle_wrap", dut.cyc_q, 32'd0);
    @(negedge clk);
    check("cycle_wrap_rd", bus.rdata, 32'd0);

    // Halt
    idle(1);
    check("halt_pre", {31'b0, halt}, 32'd0);
    wr(A_HL, 32'h0);
    check("halt_set", {31'b0, halt}, 32'd1);
    idle(3);
    check("halt_held", {31'b0, halt}, 32'd1);
    rd(A_HL, 32'h1, "halt_rd");

    // UART single byte, exact bit timing
    idle(2);
    tx_exp_q.push_back(8'h41);
    pat = {1'b1, 8'h41, 1'b0};
    wr(A_TX, 32'h41);
    bus.address = A_ST;
    check("tx_pre0", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("tx_pre1", {31'b0, tx}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 10*C; i++) begin
      check("tx_bit", {31'b0, tx}, {31'b0, pat[i/C]});
      if (i == 8) begin
        rd_exp_q.push_back(32'h6); rd_name_q.push_back("status_busy");
        rd_req = 1'b1;
      end else rd_req = 1'b0;
      @(negedge clk);
    end
    rd_req = 1'b0;
    idle(5);

    // FIFO full: byte 0 popped early, bytes 1..8 fill the FIFO, byte 9 dropped
    for (int k = 0; k < 9; k++) tx_exp_q.push_back(8'(k));
    for (int k = 0; k < 10; k++) wr(A_TX, 32'(k));
    rd(A_ST, 32'h5, "status_full");
    idle(9*(10*C+1) + 10);
    rd(A_ST, 32'h2, "status_drained");

    // Reset mid-frame flushes FIFO and aborts the frame
    wr(A_TX, 32'h55);
    wr(A_TX, 32'h66);
    idle(3*C);
    bus.address = A_ST;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", {31'b0, tx}, 32'd1);
    check("rst_mid_rdata", bus.rdata, 32'd0);
    check("rst_mid_halt", {31'b0, halt}, 32'd0);
    reset = 1'b0;
    rd(A_ST, 32'h2, "status_after_reset");
    idle(12*C);
    tx_exp_q.push_back(8'h5A);
    wr(A_TX, 32'h5A);
    idle(10*C + 10);

    // Drain with a bounded wait
    begin
      int t = 0;
      while ((tx_exp_q.size() != 0 || dbusy) && t < 1000) begin
        @(negedge clk); t++;
      end
    end
    check("uart_drain", tx_exp_q.size(), 32'd0);
    check("rd_drain", rd_exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
